vr_msg_encoder: RTL and testbench

Transmit-side serializer for replica-originated VR control messages: PrepareOK, StartViewChange and ValidateReadReply. It accepts one decoded message request with its field values and destination tuple. It emits a UDP-TX metadata beat followed by a single left-aligned NoC-width data flit carrying the beehive header plus the message body. It sits between the VR replica state logic and the UDP transmit engine, and is the encoder counterpart of the receive-side header parsers.

---
 rtl/vr_msg_encoder_pkg.sv | 82 ++++++++
 rtl/vr_msg_encoder_if.sv | 46 ++++
 rtl/vr_msg_flit_builder.sv | 83 ++++++++
 rtl/vr_msg_encoder.sv | 121 ++++++++++++
 tb/tb_vr_msg_encoder.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vr_msg_encoder_pkg.sv
// Shared types, widths and helpers for the VR control-message encoder.
// Wire layout follows the software replicas: packed structs go out MSB-first, scalar fields little-endian.
package vr_msg_encoder_pkg;

  localparam int NOC_DATA_WIDTH  = 512;
  localparam int INT_W           = 64;
  localparam int BOOL_W          = 8;
  localparam int MSG_TYPE_W      = 8;
  localparam int MSG_LEN_W       = 64;
  localparam int FRAG_MAGIC_W    = 32;
  localparam int IP_ADDR_W       = 32;
  localparam int PORT_W          = 16;
  localparam int MACHINE_TUPLE_W = IP_ADDR_W + PORT_W;

  localparam logic [FRAG_MAGIC_W-1:0] NONFRAG_MAGIC = 32'h1803_0520;

  localparam int BEEHIVE_HDR_BYTES           = 13;
  localparam int PREPARE_OK_MSG_BYTES        = 45;
  localparam int START_VIEW_CHANGE_MSG_BYTES = 37;
  localparam int VALIDATE_REPLY_MSG_BYTES    = 38;

  typedef enum logic [MSG_TYPE_W-1:0] {
    MSG_PREPARE           = 8'd5,
    MSG_PREPARE_OK        = 8'd6,
    MSG_START_VIEW_CHANGE = 8'd10,
    MSG_VALIDATE_REPLY    = 8'd14
  } msg_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_META,
    ST_DATA
  } enc_state_e;

  typedef struct packed {
    logic [FRAG_MAGIC_W-1:0] frag_num;
    logic [MSG_TYPE_W-1:0]   msg_type;
    logic [MSG_LEN_W-1:0]    msg_len;
  } beehive_hdr_t;

  typedef struct packed {
    logic [INT_W-1:0] view;
    logic [INT_W-1:0] opnum;
    logic [INT_W-1:0] rep_index;
    logic [INT_W-1:0] last_committed;
  } prepare_ok_hdr_t;

  typedef struct packed {
    logic [INT_W-1:0] view;
    logic [INT_W-1:0] rep_index;
    logic [INT_W-1:0] last_committed;
  } start_view_change_hdr_t;

  typedef struct packed {
    logic [BOOL_W-1:0] isValid;
    logic [INT_W-1:0]  clientid;
    logic [INT_W-1:0]  clientreqid;
    logic [INT_W-1:0]  rep_index;
  } validate_reply_hdr_t;

  function automatic logic [INT_W-1:0] le_swap64(input logic [INT_W-1:0] v);
    logic [INT_W-1:0] r;
    for (int i = 0; i < INT_W/8; i++) r[8*i +: 8] = v[INT_W-8-8*i +: 8];
    return r;
  endfunction

  function automatic logic [FRAG_MAGIC_W-1:0] le_swap32(input logic [FRAG_MAGIC_W-1:0] v);
    logic [FRAG_MAGIC_W-1:0] r;
    for (int i = 0; i < FRAG_MAGIC_W/8; i++) r[8*i +: 8] = v[FRAG_MAGIC_W-8-8*i +: 8];
    return r;
  endfunction

  // msg_len counts only the body, never the 13-byte beehive header itself.
  function automatic beehive_hdr_t make_hdr(input logic [MSG_TYPE_W-1:0] t, input int total_bytes);
    beehive_hdr_t h;
    h.frag_num = le_swap32(NONFRAG_MAGIC);
    h.msg_type = t;
    h.msg_len  = le_swap64(MSG_LEN_W'(total_bytes - BEEHIVE_HDR_BYTES));
    return h;
  endfunction

endpackage

// File: rtl/vr_msg_encoder_if.sv
// Request, UDP-TX metadata and data-flit signals of the VR message encoder.
// The encoder uses the slave modport; the replica/TX side uses master.
interface vr_msg_encoder_if
  import vr_msg_encoder_pkg::*;
#(
  parameter int  NOC_DATA_W = NOC_DATA_WIDTH,
  parameter int  LEN_W      = 16,
  localparam int PAD_W      = $clog2(NOC_DATA_W/8)
);
  logic                       req_val;
  logic                       req_rdy;
  logic [MSG_TYPE_W-1:0]      req_msg_type;
  logic [MACHINE_TUPLE_W-1:0] req_dst;
  logic [INT_W-1:0]           req_view;
  logic [INT_W-1:0]           req_opnum;
  logic [INT_W-1:0]           req_rep_index;
  logic [INT_W-1:0]           req_last_committed;
  logic [INT_W-1:0]           req_clientid;
  logic [INT_W-1:0]           req_clientreqid;
  logic [BOOL_W-1:0]          req_is_valid;

  logic                       meta_val;
  logic [MACHINE_TUPLE_W-1:0] meta_dst;
  logic [LEN_W-1:0]           meta_len;
  logic                       meta_rdy;

  logic                       data_val;
  logic [NOC_DATA_W-1:0]      data;
  logic                       data_last;
  logic [PAD_W-1:0]           data_padbytes;
  logic                       data_rdy;

  modport master (
    output req_val, req_msg_type, req_dst, req_view, req_opnum, req_rep_index,
           req_last_committed, req_clientid, req_clientreqid, req_is_valid,
           meta_rdy, data_rdy,
    input  req_rdy, meta_val, meta_dst, meta_len, data_val, data, data_last, data_padbytes
  );

  modport slave (
    input  req_val, req_msg_type, req_dst, req_view, req_opnum, req_rep_index,
           req_last_committed, req_clientid, req_clientreqid, req_is_valid,
           meta_rdy, data_rdy,
    output req_rdy, meta_val, meta_dst, meta_len, data_val, data, data_last, data_padbytes
  );
endinterface

// File: rtl/vr_msg_flit_builder.sv
// Combinational map from a message request to its left-aligned flit, payload length and pad count.
// Unsupported types produce an all-zero result with supported_o low.
module vr_msg_flit_builder
  import vr_msg_encoder_pkg::*;
#(
  parameter int  NOC_DATA_W = NOC_DATA_WIDTH,
  parameter int  LEN_W      = 16,
  localparam int PAD_W      = $clog2(NOC_DATA_W/8)
) (
  input  logic [MSG_TYPE_W-1:0] msg_type_i,
  input  logic [INT_W-1:0]      view_i,
  input  logic [INT_W-1:0]      opnum_i,
  input  logic [INT_W-1:0]      rep_index_i,
  input  logic [INT_W-1:0]      last_committed_i,
  input  logic [INT_W-1:0]      clientid_i,
  input  logic [INT_W-1:0]      clientreqid_i,
  input  logic [BOOL_W-1:0]     is_valid_i,
  output logic [NOC_DATA_W-1:0] flit_o,
  output logic [LEN_W-1:0]      len_o,
  output logic [PAD_W-1:0]      padbytes_o,
  output logic                  supported_o
);

  localparam int FLIT_BYTES = NOC_DATA_W/8;

  prepare_ok_hdr_t        po_body;
  start_view_change_hdr_t svc_body;
  validate_reply_hdr_t    vr_body;

  logic [8*PREPARE_OK_MSG_BYTES-1:0]        po_msg;
  logic [8*START_VIEW_CHANGE_MSG_BYTES-1:0] svc_msg;
  logic [8*VALIDATE_REPLY_MSG_BYTES-1:0]    vr_msg;

  // Every INT_W field is byte-reversed so the software replicas read it natively.
  always_comb begin
    po_body.view           = le_swap64(view_i);
    po_body.opnum          = le_swap64(opnum_i);
    po_body.rep_index      = le_swap64(rep_index_i);
    po_body.last_committed = le_swap64(last_committed_i);

    svc_body.view           = le_swap64(view_i);
    svc_body.rep_index      = le_swap64(rep_index_i);
    svc_body.last_committed = le_swap64(last_committed_i);

    vr_body.isValid     = is_valid_i;
    vr_body.clientid    = le_swap64(clientid_i);
    vr_body.clientreqid = le_swap64(clientreqid_i);
    vr_body.rep_index   = le_swap64(rep_index_i);
  end

  assign po_msg  = {make_hdr(MSG_PREPARE_OK, PREPARE_OK_MSG_BYTES), po_body};
  assign svc_msg = {make_hdr(MSG_START_VIEW_CHANGE, START_VIEW_CHANGE_MSG_BYTES), svc_body};
  assign vr_msg  = {make_hdr(MSG_VALIDATE_REPLY, VALIDATE_REPLY_MSG_BYTES), vr_body};

  always_comb begin
    flit_o      = '0;
    len_o       = '0;
    padbytes_o  = '0;
    supported_o = 1'b0;
    case (msg_type_i)
      MSG_PREPARE_OK: begin
        flit_o[NOC_DATA_W-1 -: 8*PREPARE_OK_MSG_BYTES] = po_msg;
        len_o       = LEN_W'(PREPARE_OK_MSG_BYTES);
        padbytes_o  = PAD_W'(FLIT_BYTES - PREPARE_OK_MSG_BYTES);
        supported_o = 1'b1;
      end
      MSG_START_VIEW_CHANGE: begin
        flit_o[NOC_DATA_W-1 -: 8*START_VIEW_CHANGE_MSG_BYTES] = svc_msg;
        len_o       = LEN_W'(START_VIEW_CHANGE_MSG_BYTES);
        padbytes_o  = PAD_W'(FLIT_BYTES - START_VIEW_CHANGE_MSG_BYTES);
        supported_o = 1'b1;
      end
      MSG_VALIDATE_REPLY: begin
        flit_o[NOC_DATA_W-1 -: 8*VALIDATE_REPLY_MSG_BYTES] = vr_msg;
        len_o       = LEN_W'(VALIDATE_REPLY_MSG_BYTES);
        padbytes_o  = PAD_W'(FLIT_BYTES - VALIDATE_REPLY_MSG_BYTES);
        supported_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vr_msg_encoder.sv
// Serializes one VR control message per request into a UDP-TX metadata beat followed by one data flit.
// Unsupported request types are swallowed and counted.
module vr_msg_encoder
  import vr_msg_encoder_pkg::*;
#(
  parameter int  NOC_DATA_W = NOC_DATA_WIDTH,
  parameter int  LEN_W      = 16,
  localparam int PAD_W      = $clog2(NOC_DATA_W/8)
) (
  input  logic               clk,
  input  logic               rst,
  vr_msg_encoder_if.slave    bus,
  output logic [31:0]        bad_type_cnt
);

  logic [NOC_DATA_W-1:0] bld_flit;
  logic [LEN_W-1:0]      bld_len;
  logic [PAD_W-1:0]      bld_pad;
  logic                  bld_supported;

  vr_msg_flit_builder #(
    .NOC_DATA_W (NOC_DATA_W),
    .LEN_W      (LEN_W)
  ) u_builder (
    .msg_type_i       (bus.req_msg_type),
    .view_i           (bus.req_view),
    .opnum_i          (bus.req_opnum),
    .rep_index_i      (bus.req_rep_index),
    .last_committed_i (bus.req_last_committed),
    .clientid_i       (bus.req_clientid),
    .clientreqid_i    (bus.req_clientreqid),
    .is_valid_i       (bus.req_is_valid),
    .flit_o           (bld_flit),
    .len_o            (bld_len),
    .padbytes_o       (bld_pad),
    .supported_o      (bld_supported)
  );

  enc_state_e                 state_q;
  logic                       req_rdy_q;
  logic                       meta_val_q;
  logic                       data_val_q;
  logic                       data_last_q;
  logic [NOC_DATA_W-1:0]      data_q;
  logic [LEN_W-1:0]           meta_len_q;
  logic [MACHINE_TUPLE_W-1:0] meta_dst_q;
  logic [PAD_W-1:0]           pad_q;
  logic [31:0]                bad_type_cnt_q;
  logic [31:0]                bad_type_cnt_d;

  assign bad_type_cnt_d = (bad_type_cnt_q == '1) ? bad_type_cnt_q : bad_type_cnt_q + 32'd1;

  // req_rdy is registered from the next state, so it stays low for the whole META/DATA walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      req_rdy_q      <= 1'b0;
      meta_val_q     <= 1'b0;
      data_val_q     <= 1'b0;
      data_last_q    <= 1'b0;
      data_q         <= '0;
      meta_len_q     <= '0;
      meta_dst_q     <= '0;
      pad_q          <= '0;
      bad_type_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_rdy_q <= 1'b1;
          if (bus.req_val && req_rdy_q) begin
            if (bld_supported) begin
              state_q    <= ST_META;
              req_rdy_q  <= 1'b0;
              meta_val_q <= 1'b1;
              data_q     <= bld_flit;
              meta_len_q <= bld_len;
              meta_dst_q <= bus.req_dst;
              pad_q      <= bld_pad;
            end else begin
              bad_type_cnt_q <= bad_type_cnt_d;
            end
          end
        end
        ST_META: begin
          if (bus.meta_rdy) begin
            state_q     <= ST_DATA;
            meta_val_q  <= 1'b0;
            data_val_q  <= 1'b1;
            data_last_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (bus.data_rdy) begin
            state_q     <= ST_IDLE;
            data_val_q  <= 1'b0;
            data_last_q <= 1'b0;
            req_rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_rdy_q   <= 1'b0;
          meta_val_q  <= 1'b0;
          data_val_q  <= 1'b0;
          data_last_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_rdy       = req_rdy_q;
  assign bus.meta_val      = meta_val_q;
  assign bus.meta_dst      = meta_dst_q;
  assign bus.meta_len      = meta_len_q;
  assign bus.data_val      = data_val_q;
  assign bus.data          = data_q;
  assign bus.data_last     = data_last_q;
  assign bus.data_padbytes = pad_q;
  assign bad_type_cnt      = bad_type_cnt_q;

endmodule

// File: tb/tb_vr_msg_encoder.sv
// Directed and randomized checks of vr_msg_encoder against hand-computed flits and a byte-level model.
module tb_vr_msg_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] badTypeCnt;

  int vectors     = 0;
  int miscompares = 0;

  int overlapErrs = 0;
  int orderErrs   = 0;
  int lastErrs    = 0;
  int pendingMeta = 0;

  logic [47:0]  metaDstQ[$];
  logic [15:0]  metaLenQ[$];
  logic [511:0] dataFlitQ[$];
  logic [5:0]   dataPadQ[$];

  logic [511:0] expFlitQ[$];
  logic [15:0]  expLenQ[$];
  logic [5:0]   expPadQ[$];
  logic [47:0]  expDstQ[$];
  logic         rndDone = 1'b0;

  localparam logic [47:0] DST_A = {32'h0A00_0002, 16'd51000};
  localparam logic [47:0] DST_B = {32'hC0A8_0107, 16'd7000};

  localparam logic [511:0] EXP_PO = {32'h20050318, 8'h06,
    64'h2000_0000_0000_0000, 64'h0300_0000_0000_0000, 64'h1000_0000_0000_0000,
    64'h0100_0000_0000_0000, 64'h0F00_0000_0000_0000, 152'h0};
  localparam logic [511:0] EXP_SVC = {32'h20050318, 8'h0A,
    64'h1800_0000_0000_0000, 64'h0700_0000_0000_0000, 64'h0200_0000_0000_0000,
    64'h2100_0000_0000_0000, 216'h0};
  localparam logic [511:0] EXP_VR = {32'h20050318, 8'h0E,
    64'h1900_0000_0000_0000, 8'h01, 64'h8877_6655_4433_2211,
    64'h0500_0000_0000_0000, 64'h0, 208'h0};

  vr_msg_encoder_if #(.NOC_DATA_W(512), .LEN_W(16)) bus ();

  vr_msg_encoder #(.NOC_DATA_W(512), .LEN_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .bad_type_cnt (badTypeCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Handshake monitor: captures every completed beat and checks ordering rules.
  always @(posedge clk) begin
    if (rst) begin
      pendingMeta <= 0;
    end else begin
      if (bus.meta_val && bus.data_val) overlapErrs <= overlapErrs + 1;
      if (bus.meta_val && bus.meta_rdy) begin
        metaDstQ.push_back(bus.meta_dst);
        metaLenQ.push_back(bus.meta_len);
        pendingMeta <= pendingMeta + 1;
      end else if (bus.data_val && bus.data_rdy) begin
        dataFlitQ.push_back(bus.data);
        dataPadQ.push_back(bus.data_padbytes);
        if (!bus.data_last) lastErrs <= lastErrs + 1;
        if (pendingMeta == 0) orderErrs <= orderErrs + 1;
        else pendingMeta <= pendingMeta - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] t, input logic [47:0] dst,
                               input logic [63:0] view, input logic [63:0] opnum,
                               input logic [63:0] rep, input logic [63:0] lc,
                               input logic [63:0] cid, input logic [63:0] creq,
                               input logic [7:0] isValid);
    int cycles;
    @(negedge clk);
    bus.req_msg_type       = t;
    bus.req_dst            = dst;
    bus.req_view           = view;
    bus.req_opnum          = opnum;
    bus.req_rep_index      = rep;
    bus.req_last_committed = lc;
    bus.req_clientid       = cid;
    bus.req_clientreqid    = creq;
    bus.req_is_valid       = isValid;
    bus.req_val            = 1'b1;
    cycles = 0;
    while (!bus.req_rdy && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) checkOutput("req_accept_timeout", 512'(bus.req_rdy), 512'(1'b1));
    @(negedge clk);
    bus.req_val = 1'b0;
  endtask

  // Byte-by-byte reference: header, then fields, each serialized low byte first.
  function automatic logic [511:0] modelFlit(input logic [7:0] t, input logic [63:0] view,
                                             input logic [63:0] opnum, input logic [63:0] rep,
                                             input logic [63:0] lc, input logic [63:0] cid,
                                             input logic [63:0] creq, input logic [7:0] isValid,
                                             output int nBytes);
    logic [7:0]   b[64];
    logic [63:0]  vals[4];
    logic [511:0] f;
    int n;
    int nv;
    int bodyLen;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < 4; i++) vals[i] = 64'h0;
    case (t)
      8'd6: begin
        vals[0] = view; vals[1] = opnum; vals[2] = rep; vals[3] = lc; nv = 4; bodyLen = 32;
      end
      8'd10: begin
        vals[0] = view; vals[1] = rep; vals[2] = lc; nv = 3; bodyLen = 24;
      end
      default: begin
        vals[0] = cid; vals[1] = creq; vals[2] = rep; nv = 3; bodyLen = 25;
      end
    endcase
    b[0] = 8'h20; b[1] = 8'h05; b[2] = 8'h03; b[3] = 8'h18; b[4] = t;
    for (int k = 0; k < 8; k++) b[5+k] = 8'(bodyLen >> (8*k));
    n = 13;
    if (t == 8'd14) begin
      b[n] = isValid;
      n++;
    end
    for (int j = 0; j < nv; j++) begin
      for (int k = 0; k < 8; k++) begin
        b[n] = vals[j][8*k +: 8];
        n++;
      end
    end
    f = '0;
    for (int i = 0; i < 64; i++) f[511-8*i -: 8] = b[i];
    nBytes = n;
    return f;
  endfunction

  task automatic runDirected(input string tag, input logic [7:0] t, input logic [47:0] dst,
                             input logic [63:0] view, input logic [63:0] opnum,
                             input logic [63:0] rep, input logic [63:0] lc,
                             input logic [63:0] cid, input logic [63:0] creq,
                             input logic [7:0] isValid, input logic [511:0] expFlit,
                             input logic [15:0] expLen, input logic [5:0] expPad);
    applyStimulus(t, dst, view, opnum, rep, lc, cid, creq, isValid);
    checkOutput({tag, "_meta_val"}, 512'({bus.meta_val, bus.data_val, bus.req_rdy}), 512'(3'b100));
    checkOutput({tag, "_meta_len"}, 512'(bus.meta_len), 512'(expLen));
    checkOutput({tag, "_meta_dst"}, 512'(bus.meta_dst), 512'(dst));
    @(negedge clk);
    checkOutput({tag, "_data_val"}, 512'({bus.meta_val, bus.data_val, bus.data_last}), 512'(3'b011));
    checkOutput({tag, "_flit"}, bus.data, expFlit);
    checkOutput({tag, "_pad"}, 512'(bus.data_padbytes), 512'(expPad));
    @(negedge clk);
    checkOutput({tag, "_idle"}, 512'({bus.data_val, bus.req_rdy}), 512'(2'b01));
  endtask

  initial begin
    int metaBase;
    int dataBase;
    int waitCycles;
    int nRx;
    logic anyVal;
    logic stableOk;

    bus.req_val = 1'b0;
    bus.req_msg_type = '0;
    bus.req_dst = '0;
    bus.req_view = '0;
    bus.req_opnum = '0;
    bus.req_rep_index = '0;
    bus.req_last_committed = '0;
    bus.req_clientid = '0;
    bus.req_clientreqid = '0;
    bus.req_is_valid = '0;
    bus.meta_rdy = 1'b1;
    bus.data_rdy = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_req_rdy", 512'(bus.req_rdy), 512'(1'b0));
    checkOutput("rst_vals", 512'({bus.meta_val, bus.data_val, bus.data_last}), 512'(3'b000));
    checkOutput("rst_data", bus.data, 512'h0);
    checkOutput("rst_meta", 512'({bus.meta_len, bus.meta_dst, bus.data_padbytes}), 512'h0);
    checkOutput("rst_bad_cnt", 512'(badTypeCnt), 512'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req_rdy", 512'(bus.req_rdy), 512'(1'b1));

    // One of each supported type, no stalls.
    runDirected("po", 8'd6, DST_A, 64'd3, 64'h10, 64'd1, 64'hF, 64'd0, 64'd0, 8'd0,
                EXP_PO, 16'd45, 6'd19);
    runDirected("svc", 8'd10, DST_B, 64'd7, 64'h99, 64'd2, 64'h21, 64'd0, 64'd0, 8'd0,
                EXP_SVC, 16'd37, 6'd27);
    runDirected("vr", 8'd14, DST_A, 64'd9, 64'd0, 64'd0, 64'd0, 64'h1122_3344_5566_7788,
                64'd5, 8'd1, EXP_VR, 16'd38, 6'd26);

    // Unsupported type is consumed silently and counted.
    applyStimulus(8'd5, DST_A, 64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd0, 8'd0);
    anyVal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      anyVal = anyVal | bus.meta_val | bus.data_val;
      @(negedge clk);
    end
    checkOutput("bad_no_output", 512'(anyVal), 512'(1'b0));
    checkOutput("bad_cnt", 512'(badTypeCnt), 512'd1);
    checkOutput("bad_req_rdy", 512'(bus.req_rdy), 512'(1'b1));

    // Long stalls on both handshakes.
    metaBase = metaLenQ.size();
    dataBase = dataFlitQ.size();
    bus.meta_rdy = 1'b0;
    bus.data_rdy = 1'b0;
    applyStimulus(8'd6, DST_B, 64'd3, 64'h10, 64'd1, 64'hF, 64'd0, 64'd0, 8'd0);
    stableOk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.meta_val === 1'b1 && bus.data_val === 1'b0 && bus.req_rdy === 1'b0 &&
            bus.meta_len === 16'd45 && bus.meta_dst === DST_B)) stableOk = 1'b0;
      @(negedge clk);
    end
    checkOutput("stall_meta_hold", 512'(stableOk), 512'(1'b1));
    bus.meta_rdy = 1'b1;
    @(negedge clk);
    bus.meta_rdy = 1'b0;
    stableOk = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (!(bus.data_val === 1'b1 && bus.meta_val === 1'b0 && bus.req_rdy === 1'b0 &&
            bus.data === EXP_PO && bus.data_padbytes === 6'd19 && bus.data_last === 1'b1))
        stableOk = 1'b0;
      @(negedge clk);
    end
    checkOutput("stall_data_hold", 512'(stableOk), 512'(1'b1));
    bus.data_rdy = 1'b1;
    @(negedge clk);
    checkOutput("stall_back_idle", 512'({bus.data_val, bus.req_rdy}), 512'(2'b01));
    checkOutput("stall_one_meta", 512'(metaLenQ.size() - metaBase), 512'd1);
    checkOutput("stall_one_data", 512'(dataFlitQ.size() - dataBase), 512'd1);
    bus.meta_rdy = 1'b1;

    // Reset while the flit is waiting in DATA.
    bus.data_rdy = 1'b0;
    applyStimulus(8'd6, DST_A, 64'd3, 64'h10, 64'd1, 64'hF, 64'd0, 64'd0, 8'd0);
    @(negedge clk);
    checkOutput("rstdata_in_data", 512'(bus.data_val), 512'(1'b1));
    dataBase = dataFlitQ.size();
    rst = 1'b1;
    #1;
    checkOutput("rstdata_val_drop", 512'({bus.meta_val, bus.data_val, bus.req_rdy}), 512'(3'b000));
    checkOutput("rstdata_flit_clear", bus.data, 512'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.data_rdy = 1'b1;
    @(negedge clk);
    checkOutput("rstdata_no_flit", 512'(dataFlitQ.size() - dataBase), 512'd0);
    checkOutput("rstdata_bad_cnt", 512'(badTypeCnt), 512'd0);
    runDirected("svc_after_rst", 8'd10, DST_B, 64'd7, 64'h99, 64'd2, 64'h21, 64'd0, 64'd0,
                8'd0, EXP_SVC, 16'd37, 6'd27);

    // Randomized traffic with random back-pressure.
    metaBase = metaLenQ.size();
    dataBase = dataFlitQ.size();
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [7:0]  t;
          logic [47:0] d;
          logic [63:0] v, o, r, l, c, q;
          logic [7:0]  iv;
          int nb;
          case ($urandom_range(0, 2))
            0: t = 8'd6;
            1: t = 8'd10;
            default: t = 8'd14;
          endcase
          d  = {$urandom, 16'($urandom)};
          v  = {$urandom, $urandom};
          o  = {$urandom, $urandom};
          r  = {$urandom, $urandom};
          l  = {$urandom, $urandom};
          c  = {$urandom, $urandom};
          q  = {$urandom, $urandom};
          iv = 8'($urandom_range(0, 1));
          expFlitQ.push_back(modelFlit(t, v, o, r, l, c, q, iv, nb));
          expLenQ.push_back(16'(nb));
          expPadQ.push_back(6'(64 - nb));
          expDstQ.push_back(d);
          applyStimulus(t, d, v, o, r, l, c, q, iv);
        end
        waitCycles = 0;
        while ((dataFlitQ.size() - dataBase) < 100 && waitCycles < 2000) begin
          @(negedge clk);
          waitCycles++;
        end
        rndDone = 1'b1;
      end
      begin
        while (!rndDone) begin
          @(negedge clk);
          bus.meta_rdy = ($urandom_range(0, 3) != 0);
          bus.data_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.meta_rdy = 1'b1;
    bus.data_rdy = 1'b1;

    checkOutput("rnd_meta_count", 512'(metaLenQ.size() - metaBase), 512'd100);
    checkOutput("rnd_data_count", 512'(dataFlitQ.size() - dataBase), 512'd100);
    nRx = dataFlitQ.size() - dataBase;
    if (metaLenQ.size() - metaBase < nRx) nRx = metaLenQ.size() - metaBase;
    if (nRx > 100) nRx = 100;
    for (int i = 0; i < nRx; i++) begin
      checkOutput($sformatf("rnd%0d_dst", i), 512'(metaDstQ[metaBase+i]), 512'(expDstQ[i]));
      checkOutput($sformatf("rnd%0d_len", i), 512'(metaLenQ[metaBase+i]), 512'(expLenQ[i]));
      checkOutput($sformatf("rnd%0d_flit", i), dataFlitQ[dataBase+i], expFlitQ[i]);
      checkOutput($sformatf("rnd%0d_pad", i), 512'(dataPadQ[dataBase+i]), 512'(expPadQ[i]));
    end
    checkOutput("overlap_errors", 512'(overlapErrs), 512'd0);
    checkOutput("order_errors", 512'(orderErrs), 512'd0);
    checkOutput("last_errors", 512'(lastErrs), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
